hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
ID-stage hazard and flush controller. It produces the stall/bubble controls consumed by the ID/EX pipeline register: `hazard` and `BranchBubble`. It also produces the write enables for the PC and the IF/ID register. It detects load-use and branch-operand hazards, runs a multi-cycle flush window after a taken branch, and keeps saturating stall/flush statistics plus a sticky stall watchdog.

Parameters:
FLUSH_CYCLES, 1, cycles BranchBubble/IFIDFlush are held after a taken branch (legal 1..7)
CNT_W, 16, width of the statistics counters
MAX_STALL, 4, consecutive stall cycles after which stall_err sets (legal 1..15)

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst_n  in  1  asynchronous active-low reset
id_Ra  in  5  rs field of instruction in ID
id_Rb  in  5  rt field of instruction in ID
id_UsesRa  in  1  ID instruction reads Ra
id_UsesRb  in  1  ID instruction reads Rb
id_Branch  in  1  ID instruction is a branch comparing in ID
ex_Rw  in  5  resolved destination register of EX instruction
ex_RegWr  in  1  EX instruction writes a register
ex_MemRead  in  2  EX instruction load type, 0 = not a load
mem_Rw  in  5  destination register of MEM instruction
mem_MemRead  in  2  MEM instruction load type, 0 = not a load
ex_BranchTaken  in  1  one-cycle pulse: branch in EX resolved taken
hazard  out  1  to ID/EX: insert bubble, hold ID
BranchBubble  out  1  to ID/EX: squash wrong-path instruction
PCWr  out  1  PC write enable
IFIDWr  out  1  IF/ID write enable
IFIDFlush  out  1  IF/ID clear to NOP
stall_count  out  CNT_W  saturating count of stall cycles
flush_count  out  CNT_W  saturating count of flush cycles
stall_err  out  1  sticky: stall exceeded MAX_STALL

Behaviour:
- Reset (Rst_n=0, asynchronous): FSM=RUN, flush counter=0, run-length counter=0, stall_count=0, flush_count=0, stall_err=0.
- While reset is asserted: hazard=0, BranchBubble=1, IFIDFlush=1, PCWr=0, IFIDWr=0.
- Register 0 never hazards: any match with ex_Rw=0 or mem_Rw=0 is ignored.
- Combinational hazard terms:
  - match_ex: (id_UsesRa & id_Ra==ex_Rw) | (id_UsesRb & id_Rb==ex_Rw)
  - match_mem: the same comparison using mem_Rw
  - lu = ex_MemRead!=0 & match_ex
  - br_ex = id_Branch & ex_RegWr & match_ex
  - br_mem = id_Branch & mem_MemRead!=0 & match_mem
  - stall_req = lu | br_ex | br_mem. A branch after a load therefore stalls 2 cycles: br_ex, then br_mem.
- FSM states: RUN, FLUSH.
  - RUN + ex_BranchTaken:
    - Same cycle: BranchBubble=1, IFIDFlush=1, PCWr=1 (target loads), IFIDWr=1, hazard=0.
    - If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
  - RUN, no branch, stall_req=1: hazard=1, PCWr=0, IFIDWr=0, BranchBubble=0, IFIDFlush=0.
  - RUN, idle: all outputs 0 except PCWr=1 and IFIDWr=1.
  - FLUSH:
    - BranchBubble=1, IFIDFlush=1, PCWr=1, IFIDWr=1, hazard=0.
    - Counter decrements each cycle; go to RUN when counter reaches 1.
    - stall_req is ignored because ID holds a wrong-path instruction.
- Priority: ex_BranchTaken > FLUSH > stall_req. A taken branch arriving in FLUSH reloads counter=FLUSH_CYCLES-1.
- hazard and BranchBubble are never both 1.
- Statistics:
  - stall_count increments on every cycle with hazard=1.
  - flush_count increments on every cycle with BranchBubble=1 outside reset.
  - Both saturate at all-ones and never wrap.
- Watchdog:
  - Run-length counter increments on each consecutive hazard=1 cycle and clears on any hazard=0 cycle.
  - When it reaches MAX_STALL, stall_err sets. stall_err clears only on reset.
- Reset mid-FLUSH or mid-stall returns to RUN immediately; no residual bubble after Rst_n deasserts.

Test Plan:
1. Load-use:
   - Stimulus: ex_MemRead=1, ex_Rw=5, id_Ra=5, id_UsesRa=1 for one cycle, then ex_MemRead=0.
   - Response: hazard=1, PCWr=0, IFIDWr=0 that cycle; next cycle hazard=0; stall_count=1.
   - Repeat with ex_Rw=0: hazard stays 0.
2. Branch after load:
   - Stimulus: id_Branch=1, id_Rb=7, id_UsesRb=1; load to r7 in EX (cycle 1), then in MEM (cycle 2).
   - Response: hazard=1 for exactly 2 cycles; stall_count=2; stall_err=0 with MAX_STALL=4.
3. Taken branch with FLUSH_CYCLES=3:
   - Stimulus: ex_BranchTaken pulse.
   - Response: BranchBubble=1 and IFIDFlush=1 for 3 cycles, hazard=0 throughout even with a concurrent lu condition; flush_count=3.
4. Branch overlap:
   - Stimulus: second ex_BranchTaken in the 2nd FLUSH cycle.
   - Response: window extends to 4 total bubble cycles.
5. Watchdog and saturation:
   - Stimulus: hold stall_req=1 for 5 cycles with MAX_STALL=4.
   - Response: stall_err=1 from the 4th edge and stays set after stall_req drops.
   - With CNT_W=2, stall_count saturates at 3.
6. Reset mid-flush:
   - Stimulus: assert Rst_n=0 asynchronously in FLUSH cycle 2.
   - Response: counters=0, stall_err=0 immediately; after release, the first cycle shows BranchBubble=0, PCWr=1.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard controller bus: ID/EX/MEM operand info in, pipeline stall/flush controls out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_Ra;
  logic [4:0]       id_Rb;
  logic             id_UsesRa;
  logic             id_UsesRb;
  logic             id_Branch;
  logic [4:0]       ex_Rw;
  logic             ex_RegWr;
  logic [1:0]       ex_MemRead;
  logic [4:0]       mem_Rw;
  logic [1:0]       mem_MemRead;
  logic             ex_BranchTaken;
  logic             hazard;
  logic             BranchBubble;
  logic             PCWr;
  logic             IFIDWr;
  logic             IFIDFlush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             stall_err;

  modport master (
    output id_Ra, id_Rb, id_UsesRa, id_UsesRb, id_Branch,
    output ex_Rw, ex_RegWr, ex_MemRead, mem_Rw, mem_MemRead, ex_BranchTaken,
    input  hazard, BranchBubble, PCWr, IFIDWr, IFIDFlush,
    input  stall_count, flush_count, stall_err
  );

  modport slave (
    input  id_Ra, id_Rb, id_UsesRa, id_UsesRb, id_Branch,
    input  ex_Rw, ex_RegWr, ex_MemRead, mem_Rw, mem_MemRead, ex_BranchTaken,
    output hazard, BranchBubble, PCWr, IFIDWr, IFIDFlush,
    output stall_count, flush_count, stall_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ID-stage hazard/flush controller: load-use and branch-operand stalls, taken-branch
// flush window, saturating stall/flush statistics and a sticky stall watchdog.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MAX_STALL    = 4
) (
  input logic          Clk,
  input logic          Rst_n,
  hazard_ctrl_if.slave bus
);
  localparam int unsigned FCW = 3;
  localparam int unsigned RLW = 4;
  localparam logic [FCW-1:0]   FLUSH_RELOAD = FCW'(FLUSH_CYCLES - 1);
  localparam logic [RLW:0]     STALL_LIMIT  = (RLW + 1)'(MAX_STALL);
  localparam logic [RLW-1:0]   RUN_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic [RLW-1:0]   run_q, run_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             err_q, err_d;

  logic match_ex, match_mem, lu, br_ex, br_mem, stall_req;
  logic hazard_c, bubble_c, pc_wr_c, ifid_wr_c;
  logic [RLW:0] run_inc;

  // Operand match against EX/MEM destinations; r0 is never a real producer
  always_comb begin
    match_ex  = (bus.ex_Rw != 5'd0) &&
                ((bus.id_UsesRa && (bus.id_Ra == bus.ex_Rw)) ||
                 (bus.id_UsesRb && (bus.id_Rb == bus.ex_Rw)));
    match_mem = (bus.mem_Rw != 5'd0) &&
                ((bus.id_UsesRa && (bus.id_Ra == bus.mem_Rw)) ||
                 (bus.id_UsesRb && (bus.id_Rb == bus.mem_Rw)));
    lu        = (bus.ex_MemRead != 2'd0) && match_ex;
    br_ex     = bus.id_Branch && bus.ex_RegWr && match_ex;
    br_mem    = bus.id_Branch && (bus.mem_MemRead != 2'd0) && match_mem;
    stall_req = lu || br_ex || br_mem;
  end

  // Next state and controls: taken branch beats an open flush window, which beats a stall
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    hazard_c  = 1'b0;
    bubble_c  = 1'b0;
    pc_wr_c   = 1'b1;
    ifid_wr_c = 1'b1;
    if (bus.ex_BranchTaken) begin
      bubble_c = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        fcnt_d  = FLUSH_RELOAD;
      end else begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    end else if (state_q == FLUSH) begin
      bubble_c = 1'b1;
      if (fcnt_q <= FCW'(1)) begin
        state_d = RUN;
        fcnt_d  = '0;
      end else begin
        fcnt_d = fcnt_q - FCW'(1);
      end
    end else if (stall_req) begin
      hazard_c  = 1'b1;
      pc_wr_c   = 1'b0;
      ifid_wr_c = 1'b0;
    end
    // Hold the front end squashed while in reset
    if (!Rst_n) begin
      hazard_c  = 1'b0;
      bubble_c  = 1'b1;
      pc_wr_c   = 1'b0;
      ifid_wr_c = 1'b0;
    end
  end

  // Saturating statistics and consecutive-stall watchdog
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    run_d       = '0;
    err_d       = err_q;
    run_inc     = {1'b0, run_q} + (RLW + 1)'(1);
    if (hazard_c && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (bubble_c && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (hazard_c) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_inc[RLW-1:0];
      if (run_inc >= STALL_LIMIT) err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      run_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      run_q       <= run_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.hazard       = hazard_c;
  assign bus.BranchBubble = bubble_c;
  assign bus.IFIDFlush    = bubble_c;
  assign bus.PCWr         = pc_wr_c;
  assign bus.IFIDWr       = ifid_wr_c;
  assign bus.stall_count  = stall_cnt_q;
  assign bus.flush_count  = flush_cnt_q;
  assign bus.stall_err    = err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table with a scoreboard queue, plus hand-written reset sequences.
module tb_hazard_ctrl;
  localparam logic [4:0] RUNC = 5'b00110;  // {hazard, BranchBubble, PCWr, IFIDWr, IFIDFlush}
  localparam logic [4:0] STL  = 5'b10000;
  localparam logic [4:0] BUB  = 5'b01111;
  localparam logic [4:0] RSTC = 5'b01001;

  typedef struct {
    int         id;
    logic [4:0] ra, rb, exrw, memrw;
    logic       ura, urb, br, exrwr, tk;
    logic [1:0] exmr, memmr;
    logic [4:0] ctl;
    logic [1:0] sc, fc;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tv[$];
  vec_t sb[$];
  int   grp[$];

  hazard_ctrl_if #(.CNT_W(2)) bus ();
  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(2), .MAX_STALL(4)) dut (
    .Clk(clk), .Rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, id, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [4:0] ra, logic ura, logic [4:0] rb, logic urb, logic br,
                              logic [4:0] exrw, logic exrwr, logic [1:0] exmr,
                              logic [4:0] memrw, logic [1:0] memmr, logic tk,
                              logic [4:0] ctl, logic [1:0] sc, logic [1:0] fc, logic err);
    vec_t v;
    v.id = 0; v.ra = ra; v.ura = ura; v.rb = rb; v.urb = urb; v.br = br;
    v.exrw = exrw; v.exrwr = exrwr; v.exmr = exmr; v.memrw = memrw; v.memmr = memmr;
    v.tk = tk; v.ctl = ctl; v.sc = sc; v.fc = fc; v.err = err;
    return v;
  endfunction

  function automatic vec_t idl(logic [4:0] ctl, logic [1:0] sc, logic [1:0] fc, logic err);
    return mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b0, ctl, sc, fc, err);
  endfunction

  // Load to r5 in EX while ID reads r5 through Ra
  function automatic vec_t lu5(logic tk, logic [4:0] ctl, logic [1:0] sc, logic [1:0] fc, logic err);
    return mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 2'd1, 5'd0, 2'd0, tk, ctl, sc, fc, err);
  endfunction

  function automatic void add(vec_t v);
    v.id = tv.size();
    tv.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    bus.id_Ra = v.ra; bus.id_UsesRa = v.ura; bus.id_Rb = v.rb; bus.id_UsesRb = v.urb;
    bus.id_Branch = v.br; bus.ex_Rw = v.exrw; bus.ex_RegWr = v.exrwr; bus.ex_MemRead = v.exmr;
    bus.mem_Rw = v.memrw; bus.mem_MemRead = v.memmr; bus.ex_BranchTaken = v.tk;
    sb.push_back(v);
  endtask

  task automatic chk_reset_state(input int id);
    chk("rst_ctl", id, 32'({bus.hazard, bus.BranchBubble, bus.PCWr, bus.IFIDWr, bus.IFIDFlush}), 32'(RSTC));
    chk("rst_cnt", id, 32'({bus.stall_count, bus.flush_count, bus.stall_err}), 32'd0);
  endtask

  task automatic do_reset(input int id);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state(id);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Scoreboard: compare the vector driven this cycle once outputs have settled
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      chk("ctl", e.id, 32'({bus.hazard, bus.BranchBubble, bus.PCWr, bus.IFIDWr, bus.IFIDFlush}), 32'(e.ctl));
      chk("stall_count", e.id, 32'(bus.stall_count), 32'(e.sc));
      chk("flush_count", e.id, 32'(bus.flush_count), 32'(e.fc));
      chk("stall_err", e.id, 32'(bus.stall_err), 32'(e.err));
    end
  end

  initial begin
    bus.id_Ra = '0; bus.id_Rb = '0; bus.id_UsesRa = 1'b0; bus.id_UsesRb = 1'b0; bus.id_Branch = 1'b0;
    bus.ex_Rw = '0; bus.ex_RegWr = 1'b0; bus.ex_MemRead = '0; bus.mem_Rw = '0; bus.mem_MemRead = '0;
    bus.ex_BranchTaken = 1'b0;

    // Load-use and operand-match qualifiers
    grp.push_back(tv.size());
    add(lu5(1'b0, STL, 2'd0, 2'd0, 1'b0));
    add(idl(RUNC, 2'd1, 2'd0, 1'b0));
    add(mk(5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd1, 5'd0, 2'd0, 1'b0, RUNC, 2'd1, 2'd0, 1'b0));
    add(mk(5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 2'd2, 5'd0, 2'd0, 1'b0, STL, 2'd1, 2'd0, 1'b0));
    add(mk(5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 2'd1, 5'd0, 2'd0, 1'b0, RUNC, 2'd2, 2'd0, 1'b0));
    add(mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 2'd0, 5'd0, 2'd0, 1'b0, RUNC, 2'd2, 2'd0, 1'b0));
    add(mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 5'd5, 2'd1, 1'b0, RUNC, 2'd2, 2'd0, 1'b0));
    add(mk(5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 2'd0, 5'd0, 2'd0, 1'b0, STL, 2'd2, 2'd0, 1'b0));
    add(mk(5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 2'd1, 1'b0, RUNC, 2'd3, 2'd0, 1'b0));
    add(idl(RUNC, 2'd3, 2'd0, 1'b0));

    // Branch after load: stalls in EX, then again in MEM
    grp.push_back(tv.size());
    add(mk(5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 2'd1, 5'd0, 2'd0, 1'b0, STL, 2'd0, 2'd0, 1'b0));
    add(mk(5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 2'd0, 5'd7, 2'd1, 1'b0, STL, 2'd1, 2'd0, 1'b0));
    add(mk(5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b0, RUNC, 2'd2, 2'd0, 1'b0));
    add(idl(RUNC, 2'd2, 2'd0, 1'b0));

    // Taken branch: 3-cycle window masks a concurrent load-use
    grp.push_back(tv.size());
    add(lu5(1'b1, BUB, 2'd0, 2'd0, 1'b0));
    add(lu5(1'b0, BUB, 2'd0, 2'd1, 1'b0));
    add(lu5(1'b0, BUB, 2'd0, 2'd2, 1'b0));
    add(idl(RUNC, 2'd0, 2'd3, 1'b0));
    add(lu5(1'b0, STL, 2'd0, 2'd3, 1'b0));
    add(idl(RUNC, 2'd1, 2'd3, 1'b0));

    // Second taken branch in the 2nd bubble cycle: 4 bubbles, flush_count saturates
    grp.push_back(tv.size());
    add(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b1, BUB, 2'd0, 2'd0, 1'b0));
    add(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b1, BUB, 2'd0, 2'd1, 1'b0));
    add(idl(BUB, 2'd0, 2'd2, 1'b0));
    add(idl(BUB, 2'd0, 2'd3, 1'b0));
    add(idl(RUNC, 2'd0, 2'd3, 1'b0));

    // Run length clears on a gap: 3 + 3 stalls never trip the watchdog
    grp.push_back(tv.size());
    for (int i = 0; i < 3; i++) add(lu5(1'b0, STL, 2'(i), 2'd0, 1'b0));
    add(idl(RUNC, 2'd3, 2'd0, 1'b0));
    for (int i = 0; i < 3; i++) add(lu5(1'b0, STL, 2'd3, 2'd0, 1'b0));
    add(idl(RUNC, 2'd3, 2'd0, 1'b0));

    // Five consecutive stalls: error from the 4th edge, sticky, stall_count saturates
    grp.push_back(tv.size());
    for (int i = 0; i < 5; i++) add(lu5(1'b0, STL, (i > 3) ? 2'd3 : 2'(i), 2'd0, 1'(i == 4)));
    add(idl(RUNC, 2'd3, 2'd0, 1'b1));
    add(idl(RUNC, 2'd3, 2'd0, 1'b1));

    grp.push_back(tv.size());
    for (int g = 0; g < grp.size() - 1; g++) begin
      do_reset(1000 + g);
      for (int i = grp[g]; i < grp[g+1]; i++) apply(tv[i]);
    end

    // Async reset in the 2nd flush cycle with counters and error set
    apply(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 1'b1, BUB, 2'd3, 2'd0, 1'b1));
    apply(idl(BUB, 2'd3, 2'd1, 1'b1));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state(2000);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    apply(idl(RUNC, 2'd0, 2'd0, 1'b0));
    apply(lu5(1'b0, STL, 2'd0, 2'd0, 1'b0));
    apply(idl(RUNC, 2'd1, 2'd0, 1'b0));

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
